// File: rtl/extram_arb_pkg.sv
// extram_arb_pkg
//   Shared types and constants for the external SRAM arbiter:
//   bus widths, access FSM state enum, owner encodings and the
//   default wait-state / DMA burst-limit parameter values.
package extram_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam int WAIT_STATES_DEF   = 1;
  localparam int DMA_BURST_MAX_DEF = 8;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/extram_arb_if.sv
// extram_arb_if
//   One requester port of the SRAM arbiter (CPU or DMA).
//   valid : request, held until ready
//   addr  : word address
//   wdata : write data
//   wstrb : byte strobes, 0 = read
//   ready : one-cycle completion pulse
//   rdata : read data, valid while ready=1, held until next completion
//   master modport = requester side, slave modport = arbiter side.
interface extram_arb_if;
  import extram_arb_pkg::*;

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/extram_arb_pick.sv
// extram_arb_pick
//   Winner select between CPU and DMA plus the saturating count of
//   consecutive DMA grants.
//   clk, nrst  : clock, async active-low reset
//   cpu_valid  : CPU request pending
//   dma_valid  : DMA request pending
//   grant      : the FSM takes the current winner this cycle
//   win_dma    : 1 = DMA wins, 0 = CPU wins (combinational)
module extram_arb_pick
  import extram_arb_pkg::*;
#(
  parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic cpu_valid,
  input  logic dma_valid,
  input  logic grant,
  output logic win_dma
);

  localparam int CNT_W = $clog2(DMA_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(DMA_BURST_MAX);

  logic [CNT_W-1:0] run_cnt;

  // DMA has priority until it has used up its burst allowance while the
  // CPU is waiting. A lone DMA requester is never held off.
  always_comb begin
    win_dma = 1'b0;
    if (dma_valid && !(cpu_valid && (run_cnt == RUN_MAX))) begin
      win_dma = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run_cnt <= '0;
    end else if (grant) begin
      if (win_dma) begin
        if (run_cnt != RUN_MAX) begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/extram_arbiter.sv
// extram_arbiter
//   Shares one external 32-bit SRAM port between the CPU and a DMA
//   requester. Each access holds the SRAM for WAIT_STATES+1 cycles,
//   then pulses the owner's ready for one cycle.
//   clk, nrst      : clock, async active-low reset
//   cpu_bus        : CPU requester port (slave side)
//   dma_bus        : DMA requester port (slave side)
//   extram_a       : SRAM word address
//   extram_d_out   : SRAM write data
//   extram_d_in    : SRAM read data
//   extram_cs      : SRAM select
//   extram_oe      : SRAM output enable (reads only)
//   extram_wstrb   : SRAM byte write enables
//   busy           : access in progress (ACCESS or DONE)
//   owner          : last granted requester, 0 = CPU, 1 = DMA
//
//   state  | meaning
//   IDLE   | no access; arbitrate and latch winner's request
//   ACCESS | SRAM selected; wait counter runs down to 0
//   DONE   | owner's ready pulse; SRAM deselected
module extram_arbiter
  import extram_arb_pkg::*;
#(
  parameter int WAIT_STATES   = WAIT_STATES_DEF,
  parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  extram_arb_if.slave       cpu_bus,
  extram_arb_if.slave       dma_bus,
  output logic [ADDR_W-1:0] extram_a,
  output logic [DATA_W-1:0] extram_d_out,
  input  logic [DATA_W-1:0] extram_d_in,
  output logic              extram_cs,
  output logic              extram_oe,
  output logic [STRB_W-1:0] extram_wstrb,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  arb_state_e state_q, state_d;

  logic              grant;
  logic              finish;
  logic              win_dma;
  logic              req_any;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  logic [3:0]        wait_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_out_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              cs_q;
  logic              oe_q;
  logic              busy_q;
  logic              owner_q;
  logic              cpu_ready_q;
  logic              dma_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  assign req_any = cpu_bus.valid | dma_bus.valid;

  extram_arb_pick #(
    .DMA_BURST_MAX(DMA_BURST_MAX)
  ) u_pick (
    .clk      (clk),
    .nrst     (nrst),
    .cpu_valid(cpu_bus.valid),
    .dma_valid(dma_bus.valid),
    .grant    (grant),
    .win_dma  (win_dma)
  );

  assign sel_addr  = win_dma ? dma_bus.addr  : cpu_bus.addr;
  assign sel_wdata = win_dma ? dma_bus.wdata : cpu_bus.wdata;
  assign sel_wstrb = win_dma ? dma_bus.wstrb : cpu_bus.wstrb;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every pin-facing signal is a register loaded on the grant/finish
  // strobes, so nothing on the SRAM side follows the request inputs
  // combinationally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_q      <= '0;
      a_q         <= '0;
      d_out_q     <= '0;
      wstrb_q     <= '0;
      cs_q        <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= OWNER_CPU;
      cpu_ready_q <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      dma_ack_q   <= 1'b0;
      if (grant) begin
        owner_q <= win_dma ? OWNER_DMA : OWNER_CPU;
        a_q     <= sel_addr;
        d_out_q <= sel_wdata;
        wstrb_q <= sel_wstrb;
        oe_q    <= (sel_wstrb == '0);
        cs_q    <= 1'b1;
        busy_q  <= 1'b1;
        wait_q  <= WAIT_LOAD;
      end else if (finish) begin
        cs_q    <= 1'b0;
        oe_q    <= 1'b0;
        wstrb_q <= '0;
        if (owner_q == OWNER_DMA) begin
          dma_rdata_q <= extram_d_in;
          dma_ack_q   <= 1'b1;
        end else begin
          cpu_rdata_q <= extram_d_in;
          cpu_ready_q <= 1'b1;
        end
      end else if (state_q == ACCESS) begin
        wait_q <= wait_q - 4'd1;
      end else if (state_q == DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign extram_a      = a_q;
  assign extram_d_out  = d_out_q;
  assign extram_wstrb  = wstrb_q;
  assign extram_cs     = cs_q;
  assign extram_oe     = oe_q;
  assign busy          = busy_q;
  assign owner         = owner_q;

  assign cpu_bus.ready = cpu_ready_q;
  assign cpu_bus.rdata = cpu_rdata_q;
  assign dma_bus.ready = dma_ack_q;
  assign dma_bus.rdata = dma_rdata_q;

endmodule

// File: doc/extram_arbiter.md
# extram_arbiter

Shares the single external 32-bit SRAM port between the PicoRV32 data/instruction bus and a DMA requester, such as the GD-ROM sector mover. It sits between the CPU wrapper's extram interface and the board SRAM pins. Each access is sequenced with a programmable number of wait states. A burst limit guarantees CPU progress under sustained DMA traffic.

## Interface
- WAIT_STATES, 1: extra SRAM cycles held per access (0..15)
- DMA_BURST_MAX, 8: max consecutive DMA grants while the CPU is pending (1..255)
- clk  in  1  system clock
- nrst  in  1  reset; asynchronous, active-low
- cpu_valid  in  1  CPU request; held until cpu_ready
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_wstrb  in  4  CPU byte strobes; 0 = read
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  CPU read data; valid while cpu_ready=1
- dma_req, dma_addr, dma_wdata, dma_wstrb  in  1/16/32/4  DMA request; same meaning as the CPU port
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  32  DMA read data; valid while dma_ack=1
- extram_a  out  16  SRAM address
- extram_d_out  out  32  SRAM write data
- extram_d_in  in  32  SRAM read data
- extram_cs  out  1  SRAM select
- extram_oe  out  1  output enable; reads only
- extram_wstrb  out  4  byte write enables
- busy  out  1  access in progress
- owner  out  1  0 = CPU, 1 = DMA; last granted requester

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: all extram outputs are inactive.
- IDLE, request pending:
  - Pick the winner.
  - Latch its addr, wdata and wstrb into output registers.
  - Set owner.
  - Load wait counter with WAIT_STATES.
  - Go to ACCESS.
- Arbitration:
  - DMA only: grant DMA. CPU only: grant CPU.
  - Both pending: grant DMA unless run_cnt == DMA_BURST_MAX, then grant CPU.
  - run_cnt increments (saturating) on each DMA grant and clears on each CPU grant.
  - run_cnt width is clog2(DMA_BURST_MAX+1).
- ACCESS:
  - extram_cs=1. extram_wstrb = latched wstrb. extram_oe = (latched wstrb==0).
  - Counter decrements each cycle.
  - When the counter is 0: capture extram_d_in into the owner's rdata register, assert the owner's ready/ack register, go to DONE.
- DONE:
  - cs, oe and wstrb are 0.
  - The owner's ready/ack is 1 for exactly this cycle. The other port's ready/ack stays 0.
  - Return to IDLE.
- Writes complete through the same path; rdata then holds the SRAM bus value and is don't-care.
- A request withdrawn mid-access is not legal. The arbiter still completes the latched access, and the resulting pulse is harmless.
- rdata registers hold their value until the next completion for that port.

## Timing
- Reset values: cpu_ready=0, dma_ack=0, cpu_rdata=0, dma_rdata=0, extram_a=0, extram_d_out=0, extram_cs=0, extram_oe=0, extram_wstrb=0, busy=0, owner=0, run_cnt=0, state IDLE.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronously), and the access is aborted.
- Latency: a request first seen in IDLE at cycle 0 gives ACCESS in cycles 1..WAIT_STATES+1 and ready/ack=1 in cycle WAIT_STATES+2. With WAIT_STATES=1, the pulse is in cycle 3.
- Throughput: one access per WAIT_STATES+3 cycles.
- The requester may drop or change its request on the edge ending the ready cycle. That request is sampled in the following IDLE cycle, so there are no back-to-back grants without IDLE.
- busy=1 in ACCESS and DONE.
- All outputs are registered; no combinational path from requests to extram pins.

## Structure
- Package extram_arb_pkg holds:
  - the state enum (IDLE/ACCESS/DONE);
  - owner encodings OWNER_CPU=0, OWNER_DMA=1;
  - the default WAIT_STATES and DMA_BURST_MAX constants.
- One natural sub-module, extram_arb_pick: the combinational winner select plus the saturating run_cnt register. The top level holds the FSM, wait counter and datapath registers.

## Test plan
- CPU read only, WAIT_STATES=1, SRAM word 0x0010 = 0xDEADBEEF, cpu_addr=0x0010 → extram_oe=1 in cycles 1–2, cpu_ready pulse in cycle 3 with cpu_rdata=0xDEADBEEF; dma_ack stays 0.
- DMA write dma_addr=0x0200, dma_wdata=0x12345678, dma_wstrb=4'b0011 → extram_wstrb=4'b0011 and extram_oe=0 during ACCESS, dma_ack pulse in cycle 3, only bytes 0–1 of SRAM word 0x0200 change.
- CPU and DMA both held continuously, DMA_BURST_MAX=8 → grant sequence of 8 DMA grants then 1 CPU grant, repeating.
- CPU requests alone after 8 prior DMA grants → immediate CPU grant; run_cnt clears to 0.
- WAIT_STATES=0 and WAIT_STATES=15 → ready in cycles 2 and 17 respectively.
- nrst asserted in the middle of ACCESS → cs, oe, wstrb, busy and ready/ack all 0 without waiting for a clock edge; after release, a pending request is re-granted from IDLE.
